// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: loads a parallel pattern and shifts it out LSB
// first, with hold, frame repeat and an optional idle gap between frames.
module serial_pattern_gen #(
  parameter int PATTERN_W  = 16,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PATTERN_W-1:0]         pattern,
  input  logic                         repeat_en,
  input  logic                         hold,
  output logic                         x,
  output logic                         x_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(PATTERN_W)-1:0] bit_idx
);

  localparam int IW = $clog2(PATTERN_W);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PATTERN_W - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t                 state_q;
  logic [PATTERN_W-1:0]   stored_q;
  logic [PATTERN_W-1:0]   shreg_q;
  logic [GW-1:0]          gap_q;
  logic [IW-1:0]          idx_q;
  logic                   x_q;
  logic                   xv_q;
  logic                   busy_q;
  logic                   done_q;

  // The bit on x is always shreg_q[0]; advancing shifts right and presents
  // the next bit directly, so x_q stays registered without a mux on idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      stored_q <= '0;
      shreg_q  <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      x_q      <= IDLE_BIT;
      xv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start) begin
            stored_q <= pattern;
            shreg_q  <= pattern;
            x_q      <= pattern[0];
            xv_q     <= 1'b1;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!hold) begin
            if (idx_q == LAST_IDX) begin
              done_q <= 1'b1;
              idx_q  <= '0;
              if (repeat_en) begin
                shreg_q <= stored_q;
                if (GAP_CYCLES > 0) begin
                  state_q <= ST_GAP;
                  x_q     <= IDLE_BIT;
                  xv_q    <= 1'b0;
                  gap_q   <= GAP_LOAD;
                end else begin
                  x_q <= stored_q[0];
                end
              end else begin
                state_q <= ST_DONE;
                x_q     <= IDLE_BIT;
                xv_q    <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else begin
              shreg_q <= shreg_q >> 1;
              x_q     <= shreg_q[1];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (!hold) begin
            if (gap_q == '0) begin
              state_q <= ST_SHIFT;
              x_q     <= shreg_q[0];
              xv_q    <= 1'b1;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed scenarios plus random traffic, all
// compared every cycle against a frame-timeline reference model.
module tb_serial_pattern_gen;

  localparam int W   = 16;
  localparam int GAP = 2;
  localparam bit IDL = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern;
  logic         repeat_en;
  logic         hold;
  logic         x;
  logic         x_valid;
  logic         busy;
  logic         done;
  logic [3:0]   bit_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: position along a frame timeline, 0..W-1 are bits,
  // W..W+GAP-1 are gap cycles.
  bit           m_active;
  int           m_pos;
  bit           m_done;
  logic [W-1:0] m_pat;

  logic         xq[$];
  int           dcount;

  serial_pattern_gen #(
    .PATTERN_W (W),
    .GAP_CYCLES(GAP),
    .IDLE_BIT  (IDL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pattern  (pattern),
    .repeat_en(repeat_en),
    .hold     (hold),
    .x        (x),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_done   = 1'b0;
    m_pat    = '0;
  endtask

  task automatic model_update(input logic st, input logic [W-1:0] p,
                              input logic rp, input logic hd);
    bit dn;
    dn = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_pat    = p;
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (!hd) begin
      if (m_pos == W - 1) begin
        dn = 1'b1;
        if (rp) m_pos = (GAP > 0) ? W : 0;
        else    m_active = 1'b0;
      end else begin
        m_pos++;
        if (m_pos == W + GAP) m_pos = 0;
      end
    end
    m_done = dn;
  endtask

  task automatic check_outputs();
    logic ev;
    ev = m_active && (m_pos < W);
    check("x_valid", x_valid, ev);
    check("x", x, ev ? m_pat[m_pos] : IDL);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("bit_idx", bit_idx, ev ? m_pos : 0);
  endtask

  task automatic step(input logic st, input logic [W-1:0] p,
                      input logic rp, input logic hd);
    @(negedge clk);
    check_outputs();
    if (x_valid) xq.push_back(x);
    if (done) dcount++;
    start     = st;
    pattern   = p;
    repeat_en = rp;
    hold      = hd;
    @(posedge clk);
    model_update(st, p, rp, hd);
  endtask

  task automatic clear_log();
    xq.delete();
    dcount = 0;
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] exp, input int base);
    logic [W-1:0] got;
    got = '0;
    for (int i = 0; i < W; i++)
      if (base + i < xq.size()) got[i] = xq[base + i];
    check(tag, got, exp);
  endtask

  initial begin
    logic [W-1:0] got;
    int           j;
    reset = 1'b1; start = 1'b0; pattern = '0; repeat_en = 1'b0; hold = 1'b0;
    model_reset();
    #12;
    check("rst_x", x, IDL);
    check("rst_busy", busy, 0);
    check("rst_xv", x_valid, 0);
    check("rst_idx", bit_idx, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single frame
    clear_log();
    step(1'b1, 16'b0011101111000111, 1'b0, 1'b0);
    for (int k = 0; k < 18; k++) step(1'b0, '0, 1'b0, 1'b0);
    check("t1_len", xq.size(), 16);
    check_frame("t1_bits", 16'b0011101111000111, 0);
    check("t1_done", dcount, 1);

    // 2: hold 3 cycles at bit 5
    clear_log();
    step(1'b1, 16'b0011101111000111, 1'b0, 1'b0);
    for (int k = 0; k < 40 && m_pos != 5; k++) step(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b0, 1'b0);
    check("t2_len", xq.size(), 19);
    got = '0;
    j = 0;
    for (int i = 0; i < xq.size() && j < W; i++)
      if (i < 6 || i > 8) begin got[j] = xq[i]; j++; end
    check("t2_bits", got, 16'b0011101111000111);
    check("t2_held", (xq.size() > 8) ? {xq[6], xq[7], xq[8]} : 3'b111, 3'b000);

    // 3: repeat with gap, then drop repeat_en
    clear_log();
    step(1'b1, 16'h00FF, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b0, 1'b0);
    check("t3_len", xq.size(), 32);
    check_frame("t3_f0", 16'h00FF, 0);
    check_frame("t3_f1", 16'h00FF, 16);
    check("t3_done", dcount, 2);

    // 4: start while busy is ignored
    clear_log();
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 40 && m_pos != 4; k++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b0, 1'b0);
    check("t4_len", xq.size(), 16);
    check_frame("t4_bits", 16'h0000, 0);
    check("t4_done", dcount, 1);

    // 5: async reset mid-frame
    clear_log();
    step(1'b1, 16'hC3A7, 1'b0, 1'b0);
    for (int k = 0; k < 40 && m_pos != 8; k++) step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t5_busy", busy, 0);
    check("t5_x", x, IDL);
    check("t5_xv", x_valid, 0);
    check("t5_done", done, 0);
    @(negedge clk);
    check("t5_done2", done, 0);
    reset = 1'b0;
    clear_log();
    step(1'b1, 16'hC3A7, 1'b0, 1'b0);
    for (int k = 0; k < 18; k++) step(1'b0, '0, 1'b0, 1'b0);
    check_frame("t5_replay", 16'hC3A7, 0);

    // 6: start in the DONE cycle
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int k = 0; k < 40 && !(m_done && !m_active); k++) step(1'b0, '0, 1'b0, 1'b0);
    check("t6_in_done", m_done && !m_active, 1);
    clear_log();
    step(1'b1, 16'hA5A5, 1'b0, 1'b0);
    #1;
    check("t6_first_x", x, 1);
    check("t6_first_idx", bit_idx, 0);
    for (int k = 0; k < 18; k++) step(1'b0, '0, 1'b0, 1'b0);
    check_frame("t6_bits", 16'hA5A5, 0);

    // random traffic
    for (int k = 0; k < 1500; k++)
      step(($urandom % 4) == 0, W'($urandom), $urandom % 2, ($urandom % 5) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
